// File: rtl/cdc_fifo_arb_pkg.sv
// Shared types for the source-side CDC FIFO arbiter.
package cdc_fifo_arb_pkg;

  typedef enum logic [2:0] {
    ARB      = 3'd0,
    HOLD     = 3'd1,
    CLR      = 3'd2,
    CLR_WAIT = 3'd3,
    ACK      = 3'd4
  } arb_state_e;

endpackage

// File: rtl/cdc_fifo_rr_pick.sv
// Cyclic priority pick: first valid requester at or after the pointer.
module cdc_fifo_rr_pick #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   valid,
  input  logic [IdxWidth-1:0] ptr,
  output logic [IdxWidth-1:0] idx,
  output logic                any_valid
);

  int unsigned cand_s;

  // Scan requesters starting at the pointer, wrapping modulo NumReq.
  always_comb begin
    idx       = '0;
    any_valid = 1'b0;
    cand_s    = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand_s = (int'(ptr) + i) % NumReq;
      if (!any_valid && valid[cand_s]) begin
        idx       = IdxWidth'(cand_s);
        any_valid = 1'b1;
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/cdc_fifo_src_arbiter.sv
// Round-robin sharing of a CDC FIFO source port with flush sequencing.
module cdc_fifo_src_arbiter
  import cdc_fifo_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter type T = logic [31:0],
  localparam int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic                  src_clk_i,
  input  logic                  src_rst_ni,
  input  logic [NumReq-1:0]     req_valid_i,
  input  T     [NumReq-1:0]     req_data_i,
  output logic [NumReq-1:0]     req_ready_o,
  input  logic                  flush_req_i,
  output logic                  flush_ack_o,
  output logic                  fifo_valid_o,
  output T                      fifo_data_o,
  input  logic                  fifo_ready_i,
  output logic                  fifo_clear_o,
  input  logic                  fifo_clear_pending_i,
  output logic [IdxWidth-1:0]   gnt_idx_o
);

  arb_state_e          state_r;
  logic [IdxWidth-1:0] ptr_r;
  logic [IdxWidth-1:0] hold_idx_r;
  logic                seen_pending_r;
  logic                clear_r;
  logic                ack_r;

  logic [IdxWidth-1:0] pick_idx_s;
  logic                pick_any_s;
  logic [IdxWidth-1:0] gnt_s;
  logic                gnt_valid_s;

  function automatic logic [IdxWidth-1:0] rr_next(input logic [IdxWidth-1:0] i);
    if (i == IdxWidth'(NumReq - 1)) begin
      return '0;
    end else begin
      return i + IdxWidth'(1);
    end
  endfunction

  cdc_fifo_rr_pick #(.NumReq(NumReq)) u_pick (
    .valid     (req_valid_i),
    .ptr       (ptr_r),
    .idx       (pick_idx_s),
    .any_valid (pick_any_s)
  );

  // Grant selection: live pick in ARB, latched index in HOLD, none elsewhere.
  always_comb begin
    gnt_s       = '0;
    gnt_valid_s = 1'b0;
    case (state_r)
      ARB: begin
        if (flush_req_i || fifo_clear_pending_i) begin
          gnt_valid_s = 1'b0;
        end else begin
          gnt_s       = pick_idx_s;
          gnt_valid_s = pick_any_s;
        end
      end
      HOLD: begin
        if (flush_req_i) begin
          gnt_valid_s = 1'b0;
        end else begin
          gnt_s       = hold_idx_r;
          gnt_valid_s = 1'b1;
        end
      end
      default: begin
        gnt_valid_s = 1'b0;
      end
    endcase
  end

  // Drive the FIFO and requester handshake from the current grant.
  always_comb begin
    req_ready_o  = '0;
    fifo_valid_o = gnt_valid_s;
    fifo_data_o  = '0;
    gnt_idx_o    = '0;
    if (gnt_valid_s) begin
      req_ready_o[gnt_s] = fifo_ready_i;
      fifo_data_o        = req_data_i[gnt_s];
      gnt_idx_o          = gnt_s;
    end else begin
      req_ready_o = '0;
    end
  end

  assign fifo_clear_o = clear_r;
  assign flush_ack_o  = ack_r;

  // Control FSM; clear and ack pulses are registered alongside the state.
  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      state_r        <= ARB;
      ptr_r          <= '0;
      hold_idx_r     <= '0;
      seen_pending_r <= 1'b0;
      clear_r        <= 1'b0;
      ack_r          <= 1'b0;
    end else begin
      clear_r <= 1'b0;
      ack_r   <= 1'b0;
      case (state_r)
        ARB: begin
          if (flush_req_i) begin
            state_r <= CLR;
            clear_r <= 1'b1;
          end else if (!fifo_clear_pending_i && pick_any_s) begin
            if (fifo_ready_i) begin
              ptr_r <= rr_next(pick_idx_s);
            end else begin
              hold_idx_r <= pick_idx_s;
              state_r    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (flush_req_i) begin
            state_r <= CLR;
            clear_r <= 1'b1;
          end else if (fifo_ready_i) begin
            ptr_r   <= rr_next(hold_idx_r);
            state_r <= ARB;
          end
        end
        CLR: begin
          seen_pending_r <= 1'b0;
          state_r        <= CLR_WAIT;
        end
        CLR_WAIT: begin
          if (fifo_clear_pending_i) begin
            seen_pending_r <= 1'b1;
          end
          // Wait for the far side to raise and then drop its pending flag.
          if (seen_pending_r && !fifo_clear_pending_i) begin
            state_r <= ACK;
            ack_r   <= 1'b1;
          end
        end
        ACK: begin
          state_r <= ARB;
        end
        default: begin
          state_r <= ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// Directed, table-driven bench for cdc_fifo_src_arbiter with invariant monitor.
module tb_cdc_fifo_src_arbiter;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic             flush_req;
  logic             flush_ack;
  logic             fifo_valid;
  logic [31:0]      fifo_data;
  logic             fifo_ready;
  logic             fifo_clear;
  logic             fifo_pending;
  logic [1:0]       gnt_idx;

  int errors = 0;
  int checks = 0;
  logic prev_clear = 1'b0;

  cdc_fifo_src_arbiter #(.NumReq(4)) dut (
    .src_clk_i            (clk),
    .src_rst_ni           (rst_n),
    .req_valid_i          (req_valid),
    .req_data_i           (req_data),
    .req_ready_o          (req_ready),
    .flush_req_i          (flush_req),
    .flush_ack_o          (flush_ack),
    .fifo_valid_o         (fifo_valid),
    .fifo_data_o          (fifo_data),
    .fifo_ready_i         (fifo_ready),
    .fifo_clear_o         (fifo_clear),
    .fifo_clear_pending_i (fifo_pending),
    .gnt_idx_o            (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic       ready;
    logic       flush;
    logic       pending;
    logic       e_valid;
    logic [1:0] e_idx;
    logic [3:0] e_ready;
    logic       e_clear;
    logic       e_ack;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs at the falling edge, then advance to just after the next rising edge.
  task automatic cyc(input string name, input logic ev, input logic [1:0] ei, input logic [3:0] er,
                     input logic [31:0] ed, input logic ec, input logic ea);
    @(negedge clk);
    chk({name, ".valid"}, {31'd0, fifo_valid}, {31'd0, ev});
    chk({name, ".idx"},   {30'd0, gnt_idx},    {30'd0, ei});
    chk({name, ".ready"}, {28'd0, req_ready},  {28'd0, er});
    chk({name, ".data"},  fifo_data,           ed);
    chk({name, ".clear"}, {31'd0, fifo_clear}, {31'd0, ec});
    chk({name, ".ack"},   {31'd0, flush_ack},  {31'd0, ea});
    @(posedge clk);
    #1;
  endtask

  // Structural invariants on every sampled cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(req_ready) ||
          (req_ready != 4'd0 && (req_ready != (4'd1 << gnt_idx) || !fifo_valid)) ||
          (prev_clear && fifo_clear) || (fifo_clear && fifo_valid)) begin
        errors++;
        $display("FAIL invariant: ready=%b idx=%0d valid=%0b clear=%0b prev_clear=%0b",
                 req_ready, gnt_idx, fifo_valid, fifo_clear, prev_clear);
      end
      prev_clear <= fifo_clear;
    end else begin
      prev_clear <= 1'b0;
    end
  end

  initial begin
    // valid ready flush pend | e_valid e_idx e_ready clear ack
    vecs[0]  = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0};
    vecs[1]  = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b0};
    vecs[2]  = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0};
    vecs[3]  = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b0};
    vecs[4]  = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0};
    vecs[5]  = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0};
    vecs[7]  = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
    vecs[8]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
    vecs[9]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
    vecs[10] = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
    vecs[11] = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
    vecs[12] = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1};
    vecs[13] = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b0};
    vecs[14] = '{4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0};
    vecs[15] = '{4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0};
    vecs[16] = '{4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0};
    vecs[17] = '{4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0};
    vecs[18] = '{4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0};
    vecs[19] = '{4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b0};

    rst_n = 1'b0;
    req_valid = 4'h0;
    flush_req = 1'b0;
    fifo_ready = 1'b0;
    fifo_pending = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i] = 32'hA0 + 32'(i);

    cyc("reset", 1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Round robin, flush from ARB, single requester, brief HOLD.
    for (int i = 0; i < 20; i++) begin
      req_valid    = vecs[i].valid;
      fifo_ready   = vecs[i].ready;
      flush_req    = vecs[i].flush;
      fifo_pending = vecs[i].pending;
      cyc($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_idx, vecs[i].e_ready,
          vecs[i].e_valid ? req_data[vecs[i].e_idx] : 32'h0, vecs[i].e_clear, vecs[i].e_ack);
    end
    flush_req = 1'b0;
    fifo_pending = 1'b0;

    // Stall on requester 2 with requester 0 also valid; grant must not move.
    req_data[2] = 32'h55;
    req_valid = 4'b0101;
    fifo_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc($sformatf("stall%0d", i), 1'b1, 2'd2, 4'b0000, 32'h55, 1'b0, 1'b0);
    fifo_ready = 1'b1;
    cyc("stall_hs", 1'b1, 2'd2, 4'b0100, 32'h55, 1'b0, 1'b0);
    req_valid = 4'b0001;
    cyc("after_stall", 1'b1, 2'd0, 4'b0001, 32'hA0, 1'b0, 1'b0);

    // Flush while holding requester 1; its item must come back afterwards.
    req_data[1] = 32'h77;
    req_valid = 4'b0010;
    fifo_ready = 1'b0;
    cyc("hold1", 1'b1, 2'd1, 4'b0000, 32'h77, 1'b0, 1'b0);
    fifo_pending = 1'b1;
    cyc("hold1_pend", 1'b1, 2'd1, 4'b0000, 32'h77, 1'b0, 1'b0);
    fifo_pending = 1'b0;
    flush_req = 1'b1;
    cyc("hold_retract", 1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    cyc("hold_clr", 1'b0, 2'd0, 4'b0000, 32'h0, 1'b1, 1'b0);
    cyc("hold_w0", 1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    fifo_pending = 1'b1;
    cyc("hold_w1", 1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    fifo_pending = 1'b0;
    cyc("hold_w2", 1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    cyc("hold_ack", 1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b1);
    flush_req = 1'b0;
    fifo_ready = 1'b1;
    cyc("regrant1", 1'b1, 2'd1, 4'b0010, 32'h77, 1'b0, 1'b0);

    // Far-side clear window: no grants, pointer untouched.
    req_valid = 4'hF;
    fifo_pending = 1'b1;
    for (int i = 0; i < 10; i++) cyc($sformatf("far%0d", i), 1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    fifo_pending = 1'b0;
    cyc("far_resume", 1'b1, 2'd2, 4'b0100, 32'h55, 1'b0, 1'b0);

    // Reset asserted while waiting for the clear to complete.
    req_valid = 4'h0;
    flush_req = 1'b1;
    cyc("rst_flush", 1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    cyc("rst_clr", 1'b0, 2'd0, 4'b0000, 32'h0, 1'b1, 1'b0);
    fifo_pending = 1'b1;
    cyc("rst_wait", 1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    flush_req = 1'b0;
    fifo_pending = 1'b0;
    cyc("rst_mid", 1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req_valid = 4'hF;
    fifo_ready = 1'b1;
    cyc("rst_first", 1'b1, 2'd0, 4'b0001, 32'hA0, 1'b0, 1'b0);
    cyc("rst_second", 1'b1, 2'd1, 4'b0010, 32'h77, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
